systolic_array_ctrl: RTL and testbench
======================================

Name: systolic_array_ctrl

Overview:
- Parametrised output-stationary NxN systolic MAC array for the int8 CFU datapath.
- Successor to the fixed 4x4 array. Adds generic size and widths, internal input skewing, a stall-able input handshake, a start/done command FSM, and a row-serial result drain with valid/ready backpressure.
- Sits between the operand buffers (left = activations with input offset applied, top = filters) and the output/requant stage.

Parameters:
- ARRAY_SIZE, 4, N: rows and columns of PEs.
- A_W, 9, signed width of left (activation) operands.
- B_W, 8, signed width of top (filter) operands.
- ACC_W, 32, accumulator width per PE.
- K_W, 16, width of the reduction-length field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  command pulse; sampled only in IDLE.
- k_len  in  K_W  reduction length K; captured on the accepted start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted when in_valid & in_ready.
- left_in  in  N*A_W  row i operand at bits [i*A_W +: A_W]; unskewed.
- top_in  in  N*B_W  column j operand at bits [j*B_W +: B_W]; unskewed.
- out_valid  out  1  result row valid.
- out_ready  in  1  result row consumed when out_valid & out_ready.
- out_row  out  N*ACC_W  {acc[r][0], ..., acc[r][N-1]}; acc[r][0] in the MSBs.
- out_row_idx  out  clog2(N) (min 1)  index r of the presented row.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last row handshake.

Behaviour:
- Reset: asynchronous, active-high.
  - All outputs 0. State IDLE.
  - All accumulators, skew registers and PE pipeline registers 0.
  - Reset asserted mid-operation aborts immediately. No done pulse.
- FSM: IDLE -> LOAD -> FLUSH -> DRAIN -> IDLE.
- IDLE:
  - in_ready=0.
  - On start: capture k_len, clear all accumulators and skew/pipeline registers in the same edge, beat counter=0.
  - If k_len=0, go directly to DRAIN; else go to LOAD.
- LOAD:
  - in_ready=1.
  - The array advances (skew shift, operand shift, MAC) only on cycles where in_valid=1. Otherwise the whole array holds, acting as a clock enable; no zero bubbles are inserted.
  - Counts accepted beats. On the K-th accepted beat, go to FLUSH.
  - start is ignored.
- Skew:
  - Row i passes through i registers before PE(i,0); column j passes through j registers before PE(0,j).
  - Beat k reaches PE(i,j) on advance k+i+j.
  - PE(i,j) forwards left to the right and top to the bottom, registered.
  - PE MAC: acc += sext(left) * sext(top). Full-precision A_W+B_W-bit product, sign-extended to ACC_W. Wraps modulo 2^ACC_W; no saturation.
- FLUSH:
  - in_ready=0.
  - Array advances every cycle with zeros injected at all skew inputs.
  - Lasts exactly 2N-1 cycles, then go to DRAIN.
- DRAIN:
  - out_valid=1, out_row_idx=r starting at 0, out_row = row r of the accumulators.
  - out_row and out_row_idx are held stable while out_valid & !out_ready.
  - Each handshake increments r.
  - Handshake on r=N-1: done=1 for one cycle on the following cycle, out_valid=0, return to IDLE.
  - Accumulators are frozen during DRAIN.
- Simultaneous events: start in the same cycle as the done pulse is accepted, since the state is already IDLE.
- in_valid outside LOAD has no effect.

Test Plan:
- N=4, K=4. left = I*1, top = matrix B with values -8..7 (A_W=9, B_W=8) -> rows equal B; done after 4 beats + 7 flush cycles + 4 drain handshakes.
- N=4, K=1. left_in = {3,-2,1,5}, top_in = {-1,4,2,-3} -> acc[i][j] = left[i]*top[j]; e.g. row 0 = {-3,12,6,-9}.
- k_len=0 -> IDLE to DRAIN; 4 rows of all-zero; done pulses.
- K=4 with in_valid toggled 1,0,0,1,... -> result identical to the gap-free run; in_ready stays 1 throughout LOAD.
- Drain with out_ready low for 3 cycles on row 2 -> out_row and out_row_idx=2 held stable; row 3 follows; single done pulse.
- ACC_W=16 instance, K=3, left=255, top=127 for all beats -> 97155 mod 65536 = 31619.
- Reset asserted in LOAD after 2 beats -> all outputs 0, busy=0; a new start with K=1 gives the correct result with no residue from the aborted run.
- start pulsed during FLUSH -> ignored; k_len is not re-captured.

Source files
------------

// File: rtl/systolic_array_ctrl.sv
// Output-stationary NxN systolic MAC array with internal operand skew, start/done command FSM and row-serial drain.
// Latency: K accepted beats, then 2N-1 flush cycles, then N result rows; done pulses the cycle after the last row handshake.
// Backpressure: in_valid low freezes the whole array while loading; out_ready low holds the presented row and its index.
module systolic_array_ctrl #(
   parameter int ARRAY_SIZE = 4,
   parameter int A_W        = 9,
   parameter int B_W        = 8,
   parameter int ACC_W      = 32,
   parameter int K_W        = 16,
   localparam int RW        = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        start,
   input  logic [K_W-1:0]              k_len,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [ARRAY_SIZE*A_W-1:0]   left_in,
   input  logic [ARRAY_SIZE*B_W-1:0]   top_in,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [ARRAY_SIZE*ACC_W-1:0] out_row,
   output logic [RW-1:0]               out_row_idx,
   output logic                        busy,
   output logic                        done
);
   localparam int N  = ARRAY_SIZE;
   localparam int PW = A_W + B_W;
   localparam int FW = $clog2(2 * ARRAY_SIZE);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [K_W-1:0] klen_q, klen_d;
   logic [K_W-1:0] kcnt_q, kcnt_d;
   logic [FW-1:0]  fcnt_q, fcnt_d;
   logic [RW-1:0]  row_q, row_d;
   logic           done_q, done_d;

   // clr wipes every array register on an accepted start; adv is the array-wide clock enable;
   // inj selects real operands (LOAD) versus zeros (FLUSH) at the skew inputs.
   logic clr, adv, inj;

   // Operand presented to each PE, and each PE's accumulator, visible at module level.
   logic signed [A_W-1:0] a_op  [N][N];
   logic signed [B_W-1:0] b_op  [N][N];
   logic [ACC_W-1:0]      acc_v [N][N];

   // Command FSM: next state, counters and array control strobes.
   always_comb begin
      state_d = state_q;
      klen_d  = klen_q;
      kcnt_d  = kcnt_q;
      fcnt_d  = fcnt_q;
      row_d   = row_q;
      done_d  = 1'b0;
      clr     = 1'b0;
      adv     = 1'b0;
      inj     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               clr     = 1'b1;
               klen_d  = k_len;
               kcnt_d  = '0;
               fcnt_d  = '0;
               row_d   = '0;
               // An empty reduction leaves all accumulators at zero; skip straight to the drain.
               state_d = (k_len == '0) ? S_DRAIN : S_LOAD;
            end
         end
         S_LOAD: begin
            inj = 1'b1;
            if (in_valid) begin
               adv    = 1'b1;
               kcnt_d = kcnt_q + K_W'(1);
               if (kcnt_q == klen_q - K_W'(1)) begin
                  state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            // 2N-1 zero advances carry the last beat through the skew and across to PE(N-1,N-1).
            adv    = 1'b1;
            fcnt_d = fcnt_q + FW'(1);
            if (fcnt_q == FW'(2 * N - 2)) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_ready) begin
               row_d = row_q + RW'(1);
               if (row_q == RW'(N - 1)) begin
                  row_d   = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Command FSM state and counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         klen_q  <= '0;
         kcnt_q  <= '0;
         fcnt_q  <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         klen_q  <= klen_d;
         kcnt_q  <= kcnt_d;
         fcnt_q  <= fcnt_d;
         row_q   <= row_d;
         done_q  <= done_d;
      end
   end

   assign in_ready    = (state_q == S_LOAD);
   assign out_valid   = (state_q == S_DRAIN);
   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign out_row_idx = row_q;

   // Present accumulator row r with column 0 in the most significant slot; zero outside the drain.
   always_comb begin
      out_row = '0;
      if (state_q == S_DRAIN) begin
         for (int j = 0; j < N; j++) begin
            out_row[(N - 1 - j) * ACC_W +: ACC_W] = acc_v[row_q][j];
         end
      end
   end

   // Left skew: row i is delayed by i registers so beat k meets PE(i,0) on advance k+i.
   for (genvar i = 0; i < N; i++) begin : g_lskew
      logic signed [A_W-1:0] lin;
      assign lin = inj ? left_in[i * A_W +: A_W] : '0;
      if (i == 0) begin : g_direct
         assign a_op[0][0] = lin;
      end else begin : g_sh
         logic signed [A_W-1:0] sh_q [i];
         logic signed [A_W-1:0] sh_d [i];

         // Shift the row's delay line on every array advance.
         always_comb begin
            for (int d = 0; d < i; d++) begin
               sh_d[d] = sh_q[d];
            end
            if (clr) begin
               for (int d = 0; d < i; d++) begin
                  sh_d[d] = '0;
               end
            end else if (adv) begin
               sh_d[0] = lin;
               for (int d = 1; d < i; d++) begin
                  sh_d[d] = sh_q[d - 1];
               end
            end
         end

         // Row delay-line registers.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int d = 0; d < i; d++) begin
                  sh_q[d] <= '0;
               end
            end else begin
               for (int d = 0; d < i; d++) begin
                  sh_q[d] <= sh_d[d];
               end
            end
         end
         assign a_op[i][0] = sh_q[i - 1];
      end
   end

   // Top skew: column j is delayed by j registers so beat k meets PE(0,j) on advance k+j.
   for (genvar j = 0; j < N; j++) begin : g_tskew
      logic signed [B_W-1:0] tin;
      assign tin = inj ? top_in[j * B_W +: B_W] : '0;
      if (j == 0) begin : g_direct
         assign b_op[0][0] = tin;
      end else begin : g_sh
         logic signed [B_W-1:0] sh_q [j];
         logic signed [B_W-1:0] sh_d [j];

         // Shift the column's delay line on every array advance.
         always_comb begin
            for (int d = 0; d < j; d++) begin
               sh_d[d] = sh_q[d];
            end
            if (clr) begin
               for (int d = 0; d < j; d++) begin
                  sh_d[d] = '0;
               end
            end else if (adv) begin
               sh_d[0] = tin;
               for (int d = 1; d < j; d++) begin
                  sh_d[d] = sh_q[d - 1];
               end
            end
         end

         // Column delay-line registers.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int d = 0; d < j; d++) begin
                  sh_q[d] <= '0;
               end
            end else begin
               for (int d = 0; d < j; d++) begin
                  sh_q[d] <= sh_d[d];
               end
            end
         end
         assign b_op[0][j] = sh_q[j - 1];
      end
   end

   // PE grid: each PE accumulates its operand product and forwards operands right and down, registered.
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic signed [PW-1:0] prod;
         logic [ACC_W-1:0]     acc_q, acc_d;

         // Full-precision signed product; the accumulator wraps modulo 2^ACC_W.
         assign prod = PW'(a_op[i][j]) * PW'(b_op[i][j]);

         // Accumulate on advance, clear on start, otherwise hold (this also freezes results during drain).
         always_comb begin
            acc_d = acc_q;
            if (clr) begin
               acc_d = '0;
            end else if (adv) begin
               acc_d = acc_q + ACC_W'(prod);
            end
         end

         // Accumulator register.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               acc_q <= '0;
            end else begin
               acc_q <= acc_d;
            end
         end
         assign acc_v[i][j] = acc_q;

         if (j < N - 1) begin : g_fwd_a
            logic signed [A_W-1:0] lft_q, lft_d;

            // Pass the left operand to the neighbour on the right.
            always_comb begin
               lft_d = lft_q;
               if (clr) begin
                  lft_d = '0;
               end else if (adv) begin
                  lft_d = a_op[i][j];
               end
            end

            // Rightward operand register.
            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  lft_q <= '0;
               end else begin
                  lft_q <= lft_d;
               end
            end
            assign a_op[i][j + 1] = lft_q;
         end

         if (i < N - 1) begin : g_fwd_b
            logic signed [B_W-1:0] top_q, top_d;

            // Pass the top operand to the neighbour below.
            always_comb begin
               top_d = top_q;
               if (clr) begin
                  top_d = '0;
               end else if (adv) begin
                  top_d = b_op[i][j];
               end
            end

            // Downward operand register.
            always_ff @(posedge clk or posedge reset) begin
               if (reset) begin
                  top_q <= '0;
               end else begin
                  top_q <= top_d;
               end
            end
            assign b_op[i + 1][j] = top_q;
         end
      end
   end

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl: a 32-bit and a 16-bit accumulator instance run in lockstep on shared stimulus.
// Expected rows come from a plain matrix-product model over the beats the bench issued.
// Latency and handshake expectations are counted in cycles from the start pulse.
module tb_systolic_array_ctrl;
   logic         clk, reset, start, in_valid, out_ready;
   logic [15:0]  k_len;
   logic [35:0]  left_in;
   logic [31:0]  top_in;
   logic         in_ready, out_valid, busy, done;
   logic [127:0] out_row;
   logic [1:0]   out_row_idx;
   logic         in_ready16, out_valid16, busy16, done16;
   logic [63:0]  out_row16;
   logic [1:0]   out_row_idx16;

   int total = 0;
   int bad   = 0;

   int la [64][4];
   int ta [64][4];
   int kk;
   logic [127:0] got_row [4];
   logic [63:0]  got16   [4];
   logic [1:0]   got_idx [4];
   int nrows, done_at, last_beat_cyc, ready_bad, hold_bad;

   systolic_array_ctrl #(.ARRAY_SIZE(4), .A_W(9), .B_W(8), .ACC_W(32), .K_W(16)) dut (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready), .left_in(left_in), .top_in(top_in),
      .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
      .out_row_idx(out_row_idx), .busy(busy), .done(done)
   );

   systolic_array_ctrl #(.ARRAY_SIZE(4), .A_W(9), .B_W(8), .ACC_W(16), .K_W(16)) dut16 (
      .clk(clk), .reset(reset), .start(start), .k_len(k_len),
      .in_valid(in_valid), .in_ready(in_ready16), .left_in(left_in), .top_in(top_in),
      .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16),
      .out_row_idx(out_row_idx16), .busy(busy16), .done(done16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: acc[r][c] = sum over beats of left[k][r] * top[k][c].
   function automatic logic [31:0] ref_acc(input int r, input int c);
      int s;
      s = 0;
      for (int k = 0; k < kk; k++) s += la[k][r] * ta[k][c];
      return 32'(s);
   endfunction

   function automatic logic [127:0] ref_row32(input int r);
      logic [127:0] v;
      v = '0;
      for (int c = 0; c < 4; c++) v[(3 - c) * 32 +: 32] = ref_acc(r, c);
      return v;
   endfunction

   function automatic logic [63:0] ref_row16(input int r);
      logic [63:0] v;
      logic [31:0] a;
      v = '0;
      for (int c = 0; c < 4; c++) begin
         a = ref_acc(r, c);
         v[(3 - c) * 16 +: 16] = a[15:0];
      end
      return v;
   endfunction

   task automatic fill_random(input int K);
      for (int k = 0; k < K; k++) begin
         for (int i = 0; i < 4; i++) begin
            la[k][i] = int'($urandom_range(0, 511)) - 256;
            ta[k][i] = int'($urandom_range(0, 255)) - 128;
         end
      end
   endtask

   // Issues one command from the current negedge and returns at the negedge where done is seen
   // (or when the cycle budget runs out). gap_mode: 0 none, 1 pattern 1,0,0, 2 random.
   task automatic run_op(input int K, input int gap_mode, input int stall_row,
                         input int stall_len, input bit poke_start);
      int beat, cyc, lcyc, stall_left;
      bit v;
      logic [127:0] hold_row;
      logic [1:0]   hold_idx;
      beat = 0; cyc = 0; lcyc = 0; stall_left = stall_len;
      nrows = 0; done_at = -1; last_beat_cyc = -7; ready_bad = 0; hold_bad = 0;
      hold_row = 'x; hold_idx = 'x;
      for (int r = 0; r < 4; r++) begin
         got_row[r] = 'x; got16[r] = 'x; got_idx[r] = 'x;
      end
      kk = K;
      start = 1'b1; k_len = 16'(K); in_valid = 1'b0; out_ready = 1'b0;
      while (done_at < 0 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (in_ready !== (beat < K)) ready_bad++;
         if (done === 1'b1) done_at = cyc;
         if (poke_start && beat == K && cyc == last_beat_cyc + 2) begin
            start = 1'b1;
            k_len = 16'(K + 5);
         end
         if (beat < K) begin
            case (gap_mode)
               0:       v = 1'b1;
               1:       v = (lcyc % 3 == 0);
               default: v = 1'($urandom_range(0, 1));
            endcase
            lcyc++;
         end else begin
            v = 1'($urandom_range(0, 1));
         end
         in_valid = v;
         left_in  = 36'({$urandom, $urandom});
         top_in   = $urandom;
         if (v && beat < K) begin
            for (int i = 0; i < 4; i++) begin
               left_in[i * 9 +: 9] = 9'(la[beat][i]);
               top_in[i * 8 +: 8]  = 8'(ta[beat][i]);
            end
            last_beat_cyc = cyc;
            beat++;
         end
         if (out_valid === 1'b1) begin
            if (nrows == stall_row && stall_left > 0) begin
               if (stall_left == stall_len) begin
                  hold_row = out_row; hold_idx = out_row_idx;
               end else if (out_row !== hold_row || out_row_idx !== hold_idx) begin
                  hold_bad++;
               end
               stall_left--;
               out_ready = 1'b0;
            end else begin
               if (nrows == stall_row && stall_len > 0 &&
                   (out_row !== hold_row || out_row_idx !== hold_idx)) hold_bad++;
               if (nrows < 4) begin
                  got_row[nrows] = out_row; got16[nrows] = out_row16; got_idx[nrows] = out_row_idx;
               end
               nrows++;
               out_ready = 1'b1;
            end
         end else begin
            out_ready = 1'($urandom_range(0, 1));
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total++; if ({in_ready, out_valid, busy, done} !== 4'b0) begin
         bad++; $display("FAIL reset_ctrl got=%b exp=0000", {in_ready, out_valid, busy, done}); end
      total++; if (out_row !== '0) begin bad++; $display("FAIL reset_row got=%h exp=0", out_row); end
      total++; if (out_row_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", out_row_idx); end
      total++; if ({in_ready16, out_valid16, busy16, done16, out_row_idx16} !== 6'b0 || out_row16 !== '0) begin
         bad++; $display("FAIL reset_acc16 got=%b/%h exp=0", {in_ready16, out_valid16, busy16, done16, out_row_idx16}, out_row16); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_identity();
      for (int k = 0; k < 4; k++)
         for (int i = 0; i < 4; i++) begin
            la[k][i] = (k == i) ? 1 : 0;
            ta[k][i] = k * 4 + i - 8;
         end
      run_op(4, 0, 4, 0, 1'b0);
      total++; if (done_at !== 16) begin bad++; $display("FAIL ident_done_cycle got=%0d exp=16", done_at); end
      for (int r = 0; r < 4; r++) begin
         total++; if (got_row[r] !== ref_row32(r)) begin bad++; $display("FAIL ident_row%0d got=%h exp=%h", r, got_row[r], ref_row32(r)); end
         total++; if (got_idx[r] !== 2'(r)) begin bad++; $display("FAIL ident_idx%0d got=%0d exp=%0d", r, got_idx[r], r); end
      end
      total++; if (got_row[3][31:0] !== 32'd7) begin bad++; $display("FAIL ident_b33 got=%0d exp=7", got_row[3][31:0]); end
      @(negedge clk);
      total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL ident_done_single got=%b%b exp=00", done, busy); end
   endtask

   task automatic test_outer();
      la[0][0] = 3;  la[0][1] = -2; la[0][2] = 1; la[0][3] = 5;
      ta[0][0] = -1; ta[0][1] = 4;  ta[0][2] = 2; ta[0][3] = -3;
      run_op(1, 0, 4, 0, 1'b0);
      total++; if (got_row[0] !== {32'hFFFF_FFFD, 32'd12, 32'd6, 32'hFFFF_FFF7}) begin
         bad++; $display("FAIL outer_row0 got=%h exp=fffffffd0000000c00000006fffffff7", got_row[0]); end
      total++; if (got16[0] !== {16'hFFFD, 16'd12, 16'd6, 16'hFFF7}) begin
         bad++; $display("FAIL outer_row0_16 got=%h exp=fffd000c0006fff7", got16[0]); end
      for (int r = 1; r < 4; r++) begin
         total++; if (got_row[r] !== ref_row32(r)) begin bad++; $display("FAIL outer_row%0d got=%h exp=%h", r, got_row[r], ref_row32(r)); end
      end
      total++; if (done_at !== 13) begin bad++; $display("FAIL outer_done_cycle got=%0d exp=13", done_at); end
   endtask

   task automatic test_zero_k();
      run_op(0, 0, 4, 0, 1'b0);
      total++; if (done_at !== 5) begin bad++; $display("FAIL zerok_done_cycle got=%0d exp=5", done_at); end
      total++; if (nrows !== 4) begin bad++; $display("FAIL zerok_rows got=%0d exp=4", nrows); end
      for (int r = 0; r < 4; r++) begin
         total++; if (got_row[r] !== '0 || got16[r] !== '0) begin bad++; $display("FAIL zerok_row%0d got=%h/%h exp=0", r, got_row[r], got16[r]); end
      end
   endtask

   task automatic test_gaps();
      fill_random(4);
      run_op(4, 1, 4, 0, 1'b0);
      total++; if (ready_bad !== 0) begin bad++; $display("FAIL gaps_in_ready got=%0d bad cycles exp=0", ready_bad); end
      total++; if (done_at !== 22) begin bad++; $display("FAIL gaps_done_cycle got=%0d exp=22", done_at); end
      for (int r = 0; r < 4; r++) begin
         total++; if (got_row[r] !== ref_row32(r)) begin bad++; $display("FAIL gaps_row%0d got=%h exp=%h", r, got_row[r], ref_row32(r)); end
      end
   endtask

   task automatic test_stall();
      fill_random(4);
      run_op(4, 0, 2, 3, 1'b0);
      total++; if (hold_bad !== 0) begin bad++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", hold_bad); end
      total++; if (got_idx[2] !== 2'd2 || got_idx[3] !== 2'd3) begin bad++; $display("FAIL stall_idx got=%0d,%0d exp=2,3", got_idx[2], got_idx[3]); end
      total++; if (done_at !== 19) begin bad++; $display("FAIL stall_done_cycle got=%0d exp=19", done_at); end
      for (int r = 0; r < 4; r++) begin
         total++; if (got_row[r] !== ref_row32(r)) begin bad++; $display("FAIL stall_row%0d got=%h exp=%h", r, got_row[r], ref_row32(r)); end
      end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL stall_done_single got=%b exp=0", done); end
   endtask

   task automatic test_acc16();
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 4; i++) begin
            la[k][i] = 255; ta[k][i] = 127;
         end
      run_op(3, 0, 4, 0, 1'b0);
      for (int r = 0; r < 4; r++) begin
         total++; if (got16[r] !== {4{16'd31619}}) begin bad++; $display("FAIL acc16_row%0d got=%h exp=%h", r, got16[r], {4{16'd31619}}); end
         total++; if (got_row[r] !== {4{32'd97155}}) begin bad++; $display("FAIL acc32_row%0d got=%h exp=%h", r, got_row[r], {4{32'd97155}}); end
      end
   endtask

   task automatic test_reset_abort();
      fill_random(4);
      start = 1'b1; k_len = 16'd4;
      @(negedge clk);
      start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1;
         for (int i = 0; i < 4; i++) begin
            left_in[i * 9 +: 9] = 9'(la[b][i]);
            top_in[i * 8 +: 8]  = 8'(ta[b][i]);
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL abort_midload got=%b%b exp=11", in_ready, busy); end
      reset = 1'b1;
      #1;
      total++; if ({in_ready, out_valid, busy, done, out_row_idx} !== 6'b0 || out_row !== '0) begin
         bad++; $display("FAIL abort_outputs got=%b/%h exp=0", {in_ready, out_valid, busy, done, out_row_idx}, out_row); end
      @(negedge clk);
      reset = 1'b0;
      fill_random(1);
      run_op(1, 0, 4, 0, 1'b0);
      total++; if (done_at !== 13) begin bad++; $display("FAIL abort_done_cycle got=%0d exp=13", done_at); end
      for (int r = 0; r < 4; r++) begin
         total++; if (got_row[r] !== ref_row32(r)) begin bad++; $display("FAIL abort_row%0d got=%h exp=%h", r, got_row[r], ref_row32(r)); end
      end
   endtask

   task automatic test_flush_start();
      fill_random(3);
      run_op(3, 0, 4, 0, 1'b1);
      total++; if (done_at !== 15) begin bad++; $display("FAIL flushstart_done_cycle got=%0d exp=15", done_at); end
      for (int r = 0; r < 4; r++) begin
         total++; if (got_row[r] !== ref_row32(r)) begin bad++; $display("FAIL flushstart_row%0d got=%h exp=%h", r, got_row[r], ref_row32(r)); end
      end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL flushstart_idle got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back();
      int K, srow, slen;
      for (int it = 0; it < 6; it++) begin
         K    = int'($urandom_range(1, 8));
         srow = int'($urandom_range(0, 3));
         slen = int'($urandom_range(0, 3));
         fill_random(K);
         run_op(K, 2, srow, slen, 1'b0);
         total++; if (done_at !== last_beat_cyc + 12 + slen) begin
            bad++; $display("FAIL b2b%0d_done_cycle got=%0d exp=%0d", it, done_at, last_beat_cyc + 12 + slen); end
         total++; if (ready_bad !== 0 || hold_bad !== 0) begin
            bad++; $display("FAIL b2b%0d_handshake got=%0d/%0d exp=0/0", it, ready_bad, hold_bad); end
         for (int r = 0; r < 4; r++) begin
            total++; if (got_row[r] !== ref_row32(r) || got16[r] !== ref_row16(r) || got_idx[r] !== 2'(r)) begin
               bad++; $display("FAIL b2b%0d_row%0d got=%h/%h/%0d exp=%h/%h/%0d", it, r,
                               got_row[r], got16[r], got_idx[r], ref_row32(r), ref_row16(r), r); end
         end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0;
      left_in = '0; top_in = '0; out_ready = 1'b0;
      test_reset();
      test_identity();
      test_outer();
      test_zero_k();
      test_gaps();
      test_stall();
      test_acc16();
      test_reset_abort();
      test_flush_start();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
